// File: rtl/ram_bist_ctrl.sv
// Two-pass RAM BIST controller: writes an address-derived pattern, reads it back
// through a one-cycle pipelined compare, then repeats with the inverted pattern.
module ram_bist_ctrl #(
  parameter int unsigned ram_width = 8,
  parameter int unsigned addr_size = 4,
  parameter int unsigned ram_depth = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ram_width-1:0] data_out,
  output logic                 read_en,
  output logic                 write_en,
  output logic [ram_width-1:0] data_in,
  output logic [addr_size-1:0] rd_addr,
  output logic [addr_size-1:0] wr_addr,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic [addr_size+1:0] err_count,
  output logic [addr_size-1:0] first_err_addr
);

  localparam int unsigned ErrW = addr_size + 2;
  localparam logic [addr_size-1:0] LastAddr = addr_size'(ram_depth - 1);
  localparam logic [ErrW-1:0] ErrMax = '1;

  typedef enum logic [2:0] {StIdle, StWrite, StRead, StDrain, StDone} state_e;

  state_e               state_q, state_d;
  logic                 p_q, p_d;
  logic [addr_size-1:0] addr_q, addr_d;
  logic                 read_en_q, read_en_d, write_en_q, write_en_d;
  logic [ram_width-1:0] data_in_q, data_in_d;
  logic [addr_size-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic [ErrW-1:0]      err_count_q, err_count_d;
  logic [addr_size-1:0] first_q, first_d;
  logic                 cmp_valid_q, cmp_valid_d;
  logic [addr_size-1:0] cmp_addr_q, cmp_addr_d;
  logic                 accept;

  function automatic logic [ram_width-1:0] pattern(input logic [addr_size-1:0] a, input logic p);
    logic [31:0]          s;
    logic [ram_width-1:0] v;
    s = 32'(a) + 32'd1;
    v = ram_width'(s);
    return p ? ~v : v;
  endfunction

  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    addr_d      = addr_q;
    err_count_d = err_count_q;
    first_d     = first_q;
    accept      = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          accept  = 1'b1;
          state_d = StWrite;
          p_d     = 1'b0;
          addr_d  = '0;
        end
      end
      StWrite: begin
        if (addr_q == LastAddr) begin
          state_d = StRead;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + addr_size'(1);
        end
      end
      StRead: begin
        if (addr_q == LastAddr) begin
          state_d = StDrain;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + addr_size'(1);
        end
      end
      StDrain: begin
        addr_d = '0;
        if (!p_q) begin
          p_d     = 1'b1;
          state_d = StWrite;
        end else begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered, so they are decoded from the next state.
    write_en_d = (state_d == StWrite);
    read_en_d  = (state_d == StRead);
    wr_addr_d  = write_en_d ? addr_d : wr_addr_q;
    data_in_d  = write_en_d ? pattern(addr_d, p_d) : data_in_q;
    rd_addr_d  = read_en_d ? addr_d : rd_addr_q;
    busy_d     = (state_d == StWrite) || (state_d == StRead) || (state_d == StDrain);
    done_d     = (state_d == StDone);

    // Read data arrives one cycle after the strobe, so the compare lags by one.
    cmp_valid_d = read_en_q;
    cmp_addr_d  = rd_addr_q;
    if (accept) begin
      err_count_d = '0;
      first_d     = '0;
    end else if (cmp_valid_q && (data_out != pattern(cmp_addr_q, p_q))) begin
      if (err_count_q != ErrMax) err_count_d = err_count_q + ErrW'(1);
      if (err_count_q == '0) first_d = cmp_addr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      p_q         <= 1'b0;
      addr_q      <= '0;
      read_en_q   <= 1'b0;
      write_en_q  <= 1'b0;
      data_in_q   <= '0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_count_q <= '0;
      first_q     <= '0;
      cmp_valid_q <= 1'b0;
      cmp_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      addr_q      <= addr_d;
      read_en_q   <= read_en_d;
      write_en_q  <= write_en_d;
      data_in_q   <= data_in_d;
      rd_addr_q   <= rd_addr_d;
      wr_addr_q   <= wr_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_count_q <= err_count_d;
      first_q     <= first_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_addr_q  <= cmp_addr_d;
    end
  end

  assign read_en        = read_en_q;
  assign write_en       = write_en_q;
  assign data_in        = data_in_q;
  assign rd_addr        = rd_addr_q;
  assign wr_addr        = wr_addr_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err_count      = err_count_q;
  assign first_err_addr = first_q;
  assign fail           = (err_count_q != '0);

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Scoreboard bench for ram_bist_ctrl: a faulty RAM model, an algorithmic model of
// the expected strobes and error results, and a negedge monitor that pops and compares.
module tb_ram_bist_ctrl;

  localparam int Depth = 16;
  localparam int RunLen = 2 * (2 * Depth + 1);

  logic       clk = 1'b0;
  logic       reset, start;
  logic [7:0] data_out = 8'h00;
  logic       read_en, write_en, busy, done, fail;
  logic [7:0] data_in;
  logic [3:0] rd_addr, wr_addr, first_err_addr;
  logic [5:0] err_count;

  ram_bist_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .data_out      (data_out),
    .read_en       (read_en),
    .write_en      (write_en),
    .data_in       (data_in),
    .rd_addr       (rd_addr),
    .wr_addr       (wr_addr),
    .busy          (busy),
    .done          (done),
    .fail          (fail),
    .err_count     (err_count),
    .first_err_addr(first_err_addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Fault knobs of the RAM model: per-bit stuck-at-0/1 plus one corrupt location.
  logic [7:0] and_mask = 8'hFF, or_mask = 8'h00, bad_xor = 8'h00;
  int         bad_addr = 0;
  logic [7:0] mem [Depth];

  function automatic logic [7:0] faulty(input logic [7:0] v, input int a);
    logic [7:0] x;
    x = v ^ ((a == bad_addr) ? bad_xor : 8'h00);
    return (x & and_mask) | or_mask;
  endfunction

  always @(posedge clk) begin
    if (write_en) mem[wr_addr] <= data_in;
    if (read_en) data_out <= faulty(mem[rd_addr], int'(rd_addr));
  end

  function automatic logic [7:0] exp_pat(input int a, input int p);
    logic [7:0] v;
    v = 8'(a + 1);
    return (p != 0) ? ~v : v;
  endfunction

  typedef struct {int errs; int first; int unsigned start_edge;} run_t;
  typedef struct {bit wr; int addr; int data;} strobe_t;
  run_t    run_q[$];
  strobe_t strobe_q[$];
  int      last_errs;

  // Monitor: protocol every cycle, strobe stream and end-of-run results.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    checks++;
    if (read_en === 1'b1 && write_en === 1'b1) begin
      failures++;
      $display("FAIL protocol: read_en=%b write_en=%b both high", read_en, write_en);
    end
    if (read_en === 1'b1 || write_en === 1'b1) begin
      checks++;
      if (strobe_q.size() == 0) begin
        failures++;
        $display("FAIL strobe: unexpected rd=%b wr=%b at cycle %0d, none required",
                 read_en, write_en, cyc);
      end else begin
        strobe_t s;
        int a;
        s = strobe_q.pop_front();
        a = write_en ? int'(wr_addr) : int'(rd_addr);
        if (s.wr != write_en || s.addr != a || (s.wr && s.data != int'(data_in))) begin
          failures++;
          $display("FAIL strobe: got wr=%b addr=%0d data=%0h, required wr=%b addr=%0d data=%0h",
                   write_en, a, data_in, s.wr, s.addr, s.data);
        end
      end
    end
    if (done === 1'b1 && !prev_done) begin
      checks++;
      if (run_q.size() == 0) begin
        failures++;
        $display("FAIL done: done rose with no run outstanding");
      end else begin
        run_t r;
        r = run_q.pop_front();
        if (cyc - r.start_edge != RunLen) begin
          failures++;
          $display("FAIL run_len: got %0d required %0d", cyc - r.start_edge, RunLen);
        end
        checks++;
        if (int'(err_count) != r.errs || fail !== (r.errs != 0)) begin
          failures++;
          $display("FAIL errors: got err_count=%0d fail=%b required %0d/%b",
                   err_count, fail, r.errs, r.errs != 0);
        end
        if (r.errs != 0) begin
          checks++;
          if (int'(first_err_addr) != r.first) begin
            failures++;
            $display("FAIL first_err_addr: got %0d required %0d", first_err_addr, r.first);
          end
        end
      end
    end
    prev_done = (done === 1'b1);
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask

  // Issue a run: model the whole two-pass test, queue expectations, pulse start.
  task automatic do_run(input logic [7:0] am, input logic [7:0] om, input logic [7:0] bx,
                        input int ba);
    run_t r;
    and_mask = am; or_mask = om; bad_xor = bx; bad_addr = ba;
    r.errs = 0; r.first = 0;
    for (int p = 0; p < 2; p++) begin
      for (int a = 0; a < Depth; a++) strobe_q.push_back('{1'b1, a, int'(exp_pat(a, p))});
      for (int a = 0; a < Depth; a++) begin
        strobe_q.push_back('{1'b0, a, 0});
        if (faulty(exp_pat(a, p), a) != exp_pat(a, p)) begin
          if (r.errs == 0) r.first = a;
          if (r.errs < 63) r.errs++;
        end
      end
    end
    last_errs = r.errs;
    r.start_edge = cyc + 1;
    run_q.push_back(r);
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    check("start_busy", int'(busy), 1);
    check("start_done_clr", int'(done), 0);
    check("start_err_clr", int'(err_count), 0);
  endtask

  task automatic finish_run();
    int n = 0;
    while (!(done === 1'b1 && busy === 1'b0) && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL timeout: done not seen within %0d cycles", n);
      strobe_q.delete();
      run_q.delete();
    end else begin
      repeat (3) @(negedge clk);
      #1;
      check("hold_done", int'(done), 1);
      check("hold_err", int'(err_count), last_errs);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_outputs", int'({read_en, write_en, busy, done, fail}), 0);
    check("rst_data", int'({data_in, rd_addr, wr_addr, err_count, first_err_addr}), 0);
    reset = 1'b0;
    @(negedge clk); #1;

    // Ideal RAM, then data_out[3] stuck at 0, then a clean rerun.
    do_run(8'hFF, 8'h00, 8'h00, 0);
    finish_run();
    check("ideal_fail", int'(fail), 0);
    do_run(8'hF7, 8'h00, 8'h00, 0);
    finish_run();
    check("stuck_count", int'(err_count), 16);
    check("stuck_first", int'(first_err_addr), 7);
    check("stuck_fail", int'(fail), 1);
    do_run(8'hFF, 8'h00, 8'h00, 0);
    finish_run();
    check("fixed_fail", int'(fail), 0);

    // Start pulsed again mid-run is ignored; run length is checked by the monitor.
    do_run(8'hFF, 8'h00, 8'h5A, 3);
    repeat (8) @(negedge clk);
    #1;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    finish_run();

    // Reset mid-run aborts with no further RAM access.
    do_run(8'hFF, 8'h10, 8'h00, 0);
    repeat (18) @(negedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk); #1;
    check("abort_busy", int'(busy), 0);
    check("abort_strobes", int'({read_en, write_en}), 0);
    check("abort_err", int'(err_count), 0);
    strobe_q.delete();
    run_q.delete();
    reset = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    check("abort_idle_done", int'(done), 0);

    // Randomized fault patterns.
    for (int i = 0; i < 8; i++) begin
      logic [7:0] am, om, bx;
      am = ($urandom_range(0, 1) == 0) ? ~(8'h01 << $urandom_range(0, 7)) : 8'hFF;
      om = ($urandom_range(0, 2) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
      bx = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'h00;
      do_run(am, om, bx, int'($urandom_range(0, Depth - 1)));
      finish_run();
    end

    check("queues_empty", strobe_q.size() + run_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ram_bist_ctrl.md
RAM_BIST_CTRL -- requirements
Module: ram_bist_ctrl

Interface
REQ-001 The block SHALL have parameter ram_width, default 8, meaning RAM data width in bits.
REQ-002 The block SHALL have parameter addr_size, default 4, meaning RAM address width in bits.
REQ-003 The block SHALL have parameter ram_depth, default 16, meaning number of RAM locations tested (addresses 0..ram_depth-1).
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all logic on posedge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-006 The block SHALL have port start, input, 1 bit: begin a test run, sampled at posedge.
REQ-007 The block SHALL have port data_out, input, ram_width bits: RAM read data, valid one cycle after read_en is sampled.
REQ-008 The block SHALL have port read_en, output, 1 bit: RAM read strobe.
REQ-009 The block SHALL have port write_en, output, 1 bit: RAM write strobe.
REQ-010 The block SHALL have port data_in, output, ram_width bits: RAM write data.
REQ-011 The block SHALL have port rd_addr, output, addr_size bits: RAM read address.
REQ-012 The block SHALL have port wr_addr, output, addr_size bits: RAM write address.
REQ-013 The block SHALL have port busy, output, 1 bit: high while a test run is in progress.
REQ-014 The block SHALL have port done, output, 1 bit: high once a run has completed; held until the next accepted start.
REQ-015 The block SHALL have port fail, output, 1 bit: high when err_count is nonzero.
REQ-016 The block SHALL have port err_count, output, addr_size+2 bits: number of miscompares in the current or last run.
REQ-017 The block SHALL have port first_err_addr, output, addr_size bits: address of the first miscompare; valid only while fail=1.

Function
REQ-018 All outputs SHALL be registered, except fail, which is decoded combinationally from err_count.
REQ-019 The FSM SHALL have states IDLE, WRITE, READ, DRAIN and DONE, plus a 1-bit pass counter P (0 or 1).
REQ-020 In IDLE or DONE, start=1 SHALL move the FSM to WRITE, set P=0, clear err_count and first_err_addr, clear done, and set busy.
REQ-021 start SHALL be ignored while busy=1.
REQ-022 The expected pattern SHALL be E(a)=(a+1) truncated to ram_width bits when P=0, and ~(a+1) when P=1.
REQ-023 WRITE SHALL run ram_depth cycles, one per address a=0..ram_depth-1, with write_en=1, wr_addr=a and data_in=E(a); read_en SHALL be 0 during WRITE.
REQ-024 READ SHALL run ram_depth cycles with read_en=1 and rd_addr=a, a=0..ram_depth-1; write_en SHALL be 0 during READ.
REQ-025 The compare SHALL be pipelined: in the cycle after each read is issued, data_out is compared with E of the delayed address.
REQ-026 DRAIN SHALL last 1 cycle with read_en=0 and SHALL perform the compare for the last address.
REQ-027 After DRAIN with P=0, the FSM SHALL set P=1 and return to WRITE; after DRAIN with P=1, it SHALL go to DONE.
REQ-028 Run length from the start-sampling edge to done=1 SHALL be exactly 2*(2*ram_depth+1) cycles, i.e. 66 with the defaults.
REQ-029 On each miscompare, err_count SHALL increment by 1; if err_count was 0 before the increment, first_err_addr SHALL capture the compared address.
REQ-030 err_count SHALL saturate at its maximum value.
REQ-031 In DONE, busy SHALL be 0, done SHALL be 1, and err_count, first_err_addr and fail SHALL hold their values.
REQ-032 Addresses SHALL wrap from ram_depth-1 to 0 at each phase boundary, with no extra idle cycle between WRITE and READ or between DRAIN and WRITE.

Reset
REQ-033 reset=1 at a posedge SHALL force IDLE, P=0, and all registered outputs to 0 (read_en, write_en, data_in, rd_addr, wr_addr, busy, done, err_count, first_err_addr), with fail=0 as a result.
REQ-034 reset SHALL take priority over start and SHALL abort a run mid-operation with no further RAM strobes.

Verification
REQ-035 Scenario 1: ideal 16x8 RAM model, pulse start -> write_en high for cycles 1-16 with data 1..16; done=1 at cycle 66; err_count=0; fail=0.
REQ-036 Scenario 2: RAM model with data_out[3] stuck at 0 -> err_count=16 (8 errors per pass); first_err_addr=7; fail=1.
REQ-037 Scenario 3: assert reset at cycle 20 of a run -> on the next edge busy=0, read_en=0, write_en=0, err_count=0; no RAM access until a new start.
REQ-038 Scenario 4: pulse start again at cycle 10 of a run -> ignored; done still at cycle 66 measured from the first start.
REQ-039 Scenario 5: a failing run followed by start on a fixed RAM -> err_count cleared at the start edge; run ends with fail=0 and done=1.
REQ-040 Scenario 6: check the protocol every cycle -> read_en and write_en are never both 1; rd_addr and wr_addr are always < 16.
